lr_stream_writer: RTL and testbench
===================================

Name: lr_stream_writer

Overview:
- Write-side initiator for the 16 KB, 32-bit local RAM.
- Accepts a byte stream from the Ethernet receive path using a valid/ready handshake.
- Packs bytes little-endian into 32-bit words and drives the RAM port: word address [13:2], 32-bit data, per-byte write enables, clock enable.
- Reports the byte count and overflow status when the frame ends, so a core can pick up the packet from local RAM.

Parameters:
- MAX_WORD, 12'hFFF, last writable word address; writes beyond it are dropped.

Ports:
- clk  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a frame (honoured only in IDLE).
- base_addr  input  12  word address [13:2] of the frame's first word; latched on start.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_eop  input  1  qualifies the last byte of the frame (with in_valid).
- in_ready  output  1  writer accepts a byte this cycle.
- mem_addr  output  12  RAM word address [13:2].
- mem_data  output  32  RAM write data.
- mem_we  output  4  byte-lane write enables; bit k covers data[8k+7:8k].
- mem_en  output  1  RAM clock enable; high only in write cycles.
- done  output  1  one-cycle pulse at frame end.
- byte_count  output  15  bytes accepted in the last frame; held until the next start.
- overflow  output  1  last frame exceeded MAX_WORD; held until the next start.

Behaviour:
- Reset values (reset low, asynchronous): all outputs 0, state IDLE, packing register 0, lane index 0.
- A byte is accepted when in_valid && in_ready.
- in_ready = 1 only in state RECV. The RAM accepts one write per cycle, so the writer never back-pressures mid-frame.
- IDLE:
  - start=1: latch base_addr into the word pointer, clear byte_count, overflow and the lane index, go to RECV.
  - start outside IDLE is ignored.
- RECV:
  - Each accepted byte goes to lane = lane index (0..3). Lane index increments modulo 4; byte_count increments.
  - Accepting lane 3 without eop: in the next cycle mem_en=1, mem_we=4'hF, mem_addr=pointer, mem_data=packed word. The pointer then increments and the lane mask clears.
  - Write latency is 1 cycle after the accepting edge. The next byte may be accepted in that same cycle, into lane 0 of the next word; the packing register is double-buffered for this.
  - Accepted byte with in_eop=1 → go to FLUSH.
- FLUSH (1 cycle):
  - Issue the final write with mem_we = mask of the lanes filled in the current word (e.g. 2 bytes → 4'b0011, 4 bytes → 4'hF). Unfilled lanes of mem_data are 0.
  - Go to DONE.
- DONE (1 cycle): done=1, then return to IDLE.
- mem_en / mem_we are 0 in every cycle that is not a write cycle.
- Overflow:
  - When a write would target pointer > MAX_WORD, the write is suppressed (mem_en=0, mem_we=0) and overflow is set.
  - Bytes continue to be accepted and counted until eop.
  - The pointer saturates and never wraps to 0.
- byte_count saturates at 15'h7FFF.
- in_valid with in_eop on the very first byte: 1-byte frame, mem_we=4'b0001, byte_count=1.
- Reset mid-frame: immediate return to IDLE, no write, no done pulse. The partially written RAM contents are left as they are.
- in_valid while not in RECV: not accepted (in_ready=0), no effect.

Test Plan:
- Reset, then start with base_addr=12'h010, 8 bytes 0x01..0x08 (eop on 0x08) → two writes:
  - addr 010, data 32'h04030201, we F;
  - addr 011, data 32'h08070605, we F;
  - then done pulse, byte_count=8, overflow=0.
- start base_addr=12'h020, 6 bytes 0xA0..0xA5 → writes:
  - addr 020, data 32'hA3A2A1A0, we F;
  - addr 021, data 32'h0000A5A4, we 4'b0011;
  - byte_count=6.
- Single byte 0x5C with eop at base_addr=0 → one write: addr 000, data 32'h0000005C, we 4'b0001; done; byte_count=1.
- base_addr=12'hFFF, 12 bytes → only addr FFF is written (we F). The following two words are suppressed with mem_en=0; overflow=1, byte_count=12, done pulses.
- Continuous in_valid, 16 bytes back-to-back → in_ready stays 1 throughout, 4 writes to consecutive addresses one cycle after each 4th byte, no dropped bytes.
- Assert reset low after 5 bytes of a frame → all outputs 0 immediately, no done. A subsequent start with 4 bytes → a normal write with we F, byte_count=4.

Source files
------------

// File: rtl/lr_stream_writer.sv
// lr_stream_writer: packs a byte stream little-endian into 32-bit words and writes them to local RAM.
module lr_stream_writer #(
    parameter logic [11:0] MAX_WORD = 12'hFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [11:0] base_addr,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_eop,
    output logic        in_ready,
    output logic [11:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_we,
    output logic        mem_en,
    output logic        done,
    output logic [14:0] byte_count,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, RECV, FLUSH, DONE} state_t;
    state_t      state;
    // one extra pointer bit lets the pointer sit just past MAX_WORD without wrapping
    logic [12:0] ptr;
    logic [1:0]  lane;
    logic [31:0] pack;
    logic [3:0]  mask;
    logic        acc;
    logic        ok;
    logic [31:0] word;
    logic [3:0]  mask_n;
    assign in_ready = state == RECV;
    always_comb begin
        acc    = in_valid && in_ready;
        ok     = ptr <= {1'b0, MAX_WORD};
        word   = pack | ({24'd0, in_data} << {lane, 3'b000});
        mask_n = mask | (4'b0001 << lane);
    end
    // the mem_* output registers act as the second packing buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            ptr        <= '0;
            lane       <= '0;
            pack       <= '0;
            mask       <= '0;
            mem_addr   <= '0;
            mem_data   <= '0;
            mem_we     <= '0;
            mem_en     <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
            overflow   <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            mem_we <= '0;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ptr        <= {1'b0, base_addr};
                    lane       <= '0;
                    pack       <= '0;
                    mask       <= '0;
                    byte_count <= '0;
                    overflow   <= 1'b0;
                    state      <= RECV;
                end
                RECV: if (acc) begin
                    lane       <= lane + 2'd1;
                    byte_count <= (byte_count == 15'h7FFF) ? byte_count : byte_count + 15'd1;
                    if (in_eop || lane == 2'd3) begin
                        mem_addr <= ptr[11:0];
                        mem_data <= word;
                        mem_en   <= ok;
                        mem_we   <= ok ? mask_n : 4'd0;
                        overflow <= overflow | !ok;
                        ptr      <= ok ? ptr + 13'd1 : ptr;
                        pack     <= '0;
                        mask     <= '0;
                    end else begin
                        pack <= word;
                        mask <= mask_n;
                    end
                    if (in_eop) state <= FLUSH;
                end
                FLUSH: begin
                    done  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lr_stream_writer.sv
// tb_lr_stream_writer: directed frames with hand-computed RAM writes, counts and flags.
module tb_lr_stream_writer;
    logic        clk = 0;
    logic        reset = 0;
    logic        start = 0;
    logic [11:0] base_addr = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 0;
    logic        in_eop = 0;
    logic        in_ready;
    logic [11:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_we;
    logic        mem_en;
    logic        done;
    logic [14:0] byte_count;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int we_leak = 0;
    logic [11:0] wa[$];
    logic [31:0] wd[$];
    logic [3:0]  ww[$];

    lr_stream_writer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_data(in_data), .in_valid(in_valid), .in_eop(in_eop), .in_ready(in_ready),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_en(mem_en),
        .done(done), .byte_count(byte_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_en) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_data);
            ww.push_back(mem_we);
        end
        if (done) done_cnt++;
        if (!mem_en && mem_we != 4'd0) we_leak++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input int idx, input logic [11:0] a, input logic [31:0] d, input logic [3:0] w);
        if (idx < wa.size()) begin
            chk("wr_addr", {20'd0, wa[idx]}, {20'd0, a});
            chk("wr_data", wd[idx], d);
            chk("wr_we", {28'd0, ww[idx]}, {28'd0, w});
        end else begin
            chk("wr_missing", wa.size(), idx + 1);
        end
    endtask

    task automatic frame(input logic [11:0] base, input int n, input logic [7:0] b0);
        wa.delete();
        wd.delete();
        ww.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1;
        base_addr = base;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < n; i++) begin
            in_data = b0 + 8'(i);
            in_valid = 1;
            in_eop = (i == n - 1);
            chk("in_ready", in_ready, 1);
            @(negedge clk);
            in_valid = 0;
            in_eop = 0;
            chk("wr_lat", mem_en, ((i % 4 == 3) || (i == n - 1)) && (int'(base) + i / 4 <= 4095));
        end
        repeat (4) @(negedge clk);
        #1;
        chk("done", done_cnt, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_out", {in_ready, mem_addr, mem_we, mem_en, done, byte_count, overflow}, 0);
        chk("rst_data", mem_data, 0);
        reset = 1;
        @(negedge clk);
        in_valid = 1;
        in_eop = 1;
        in_data = 8'h77;
        chk("idle_ready", in_ready, 0);
        repeat (3) @(negedge clk);
        in_valid = 0;
        in_eop = 0;
        chk("idle_nowr", wa.size(), 0);
        chk("idle_cnt", byte_count, 0);

        frame(12'h010, 8, 8'h01);
        chk("f1_nwr", wa.size(), 2);
        chk_wr(0, 12'h010, 32'h04030201, 4'hF);
        chk_wr(1, 12'h011, 32'h08070605, 4'hF);
        chk("f1_cnt", byte_count, 8);
        chk("f1_ovf", overflow, 0);

        frame(12'h020, 6, 8'hA0);
        chk("f2_nwr", wa.size(), 2);
        chk_wr(0, 12'h020, 32'hA3A2A1A0, 4'hF);
        chk_wr(1, 12'h021, 32'h0000A5A4, 4'b0011);
        chk("f2_cnt", byte_count, 6);

        frame(12'h000, 1, 8'h5C);
        chk("f3_nwr", wa.size(), 1);
        chk_wr(0, 12'h000, 32'h0000005C, 4'b0001);
        chk("f3_cnt", byte_count, 1);

        frame(12'hFFF, 12, 8'h00);
        chk("f4_nwr", wa.size(), 1);
        chk_wr(0, 12'hFFF, 32'h03020100, 4'hF);
        chk("f4_ovf", overflow, 1);
        chk("f4_cnt", byte_count, 12);

        frame(12'h100, 16, 8'h10);
        chk("f5_nwr", wa.size(), 4);
        chk_wr(0, 12'h100, 32'h13121110, 4'hF);
        chk_wr(1, 12'h101, 32'h17161514, 4'hF);
        chk_wr(2, 12'h102, 32'h1B1A1918, 4'hF);
        chk_wr(3, 12'h103, 32'h1F1E1D1C, 4'hF);
        chk("f5_cnt", byte_count, 16);
        chk("f5_ovf", overflow, 0);

        done_cnt = 0;
        @(negedge clk);
        start = 1;
        base_addr = 12'h200;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'hC0 + 8'(i);
            in_valid = 1;
            @(negedge clk);
        end
        in_valid = 0;
        chk("pre_rst_cnt", byte_count, 5);
        #1;
        reset = 0;
        #1;
        chk("mid_rst_out", {in_ready, mem_addr, mem_we, mem_en, done, byte_count, overflow}, 0);
        chk("mid_rst_data", mem_data, 0);
        repeat (2) @(negedge clk);
        reset = 1;
        repeat (3) @(negedge clk);
        chk("mid_rst_done", done_cnt, 0);

        frame(12'h300, 4, 8'hE0);
        chk("f6_nwr", wa.size(), 1);
        chk_wr(0, 12'h300, 32'hE3E2E1E0, 4'hF);
        chk("f6_cnt", byte_count, 4);

        chk("we_leak", we_leak, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
